// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding, default
// bus widths and a counter-width helper.
package mips_mem_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_XFER = 2'd1;
  localparam logic [1:0] ST_DM_XFER = 2'd2;
  localparam logic [1:0] ST_IF_DROP = 2'd3;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int ctr_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mips_sat_ctr.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module mips_sat_ctr #(
  parameter int          W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the single unified memory between instruction fetch and the
// MEM stage; one transaction in flight, data first, fetch protected from starvation.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int          AW           = AW_DEF,
  parameter int          DW           = DW_DEF,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic          if_ack_o,
  output logic          if_err_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_ack_o,
  output logic          dm_err_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          busy_o
);

  localparam int SW = ctr_width(STARVE_LIMIT);
  localparam int TW = ctr_width(TIMEOUT);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TmoLast   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic          dm_ack_q, dm_ack_d, dm_err_q, dm_err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          if_elig, dm_elig, gnt_if, gnt_dm, tmo_hit, xfer_end;

  // A port is not re-granted while its own ack is still showing.
  assign if_elig  = if_req_i & ~if_ack_q & ~if_flush_i;
  assign dm_elig  = dm_req_i & ~dm_ack_q;
  assign gnt_if   = (state_q == ST_IDLE) & if_elig & (~dm_elig | (starve_cnt == StarveMax));
  assign gnt_dm   = (state_q == ST_IDLE) & dm_elig & ~gnt_if;
  // tmo_cnt counts completed request cycles, so TmoLast marks the final allowed one.
  assign tmo_hit  = (TIMEOUT != 0) && mem_req_q && !mem_ready_i && (tmo_cnt == TmoLast);
  assign xfer_end = mem_req_q & (mem_ready_i | tmo_hit);

  mips_sat_ctr #(.W(SW), .MAX(STARVE_LIMIT)) u_starve_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (gnt_if),
    .inc_i  (gnt_dm & if_elig),
    .cnt_o  (starve_cnt)
  );

  mips_sat_ctr #(.W(TW), .MAX(TIMEOUT)) u_tmo_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (~mem_req_q | xfer_end),
    .inc_i  (mem_req_q),
    .cnt_o  (tmo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_err_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_if || gnt_dm) begin
          mem_req_d   = 1'b1;
          mem_we_d    = gnt_dm & dm_we_i;
          mem_addr_d  = gnt_if ? if_addr_i : dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          state_d     = gnt_if ? ST_IF_XFER : ST_DM_XFER;
        end
      end
      ST_IF_XFER: begin
        if (xfer_end) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (!if_flush_i) begin
            if_ack_d = 1'b1;
            if_err_d = ~mem_ready_i;
            if (mem_ready_i) begin
              if_rdata_d = mem_rdata_i;
            end
          end
        end else if (if_flush_i) begin
          state_d = ST_IF_DROP;
        end
      end
      ST_DM_XFER: begin
        if (xfer_end) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          dm_ack_d  = 1'b1;
          dm_err_d  = ~mem_ready_i;
          if (mem_ready_i && !mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      ST_IF_DROP: begin
        if (xfer_end) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_err_q    <= if_err_d;
      dm_ack_q    <= dm_ack_d;
      dm_err_q    <= dm_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_ack_o    = dm_ack_q;
  assign dm_err_o    = dm_err_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
